// File: rtl/jtframe_rom_req_pkg.sv
// jtframe_rom_req_pkg: state encoding, timeout limit and
// address-split helper shared by the ROM requester and its cache.
package jtframe_rom_req_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    localparam logic [7:0] TIMEOUT = 8'd255;

    // Address bits that select a DW slice inside a 32-bit word
    function automatic int lsb_w(input int dw);
        return (dw == 32) ? 0 : (dw == 16) ? 1 : 2;
    endfunction

endpackage

// File: rtl/jtframe_rom_req_cache.sv
// jtframe_rom_req_cache: 2-entry tag/valid/data store with round-robin
// replacement.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   flush             clears all valid bits
//   lookup, tag       lookup strobe and tag
//   hit, hit_data     hit flag and the word of the hitting entry
//   we, wtag, wdata   fill of the entry under ptr (ptr then toggles)
module jtframe_rom_req_cache
    import jtframe_rom_req_pkg::*;
#(
    parameter int TW = 16
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          lookup,
    input  logic [TW-1:0] tag,
    output logic          hit,
    output logic [31:0]   hit_data,
    input  logic          we,
    input  logic [TW-1:0] wtag,
    input  logic [31:0]   wdata
);

    logic [1:0]    valid;
    logic          ptr;
    logic [TW-1:0] tag0, tag1;
    logic [31:0]   data0, data1;
    logic          hit0, hit1;

    assign hit0     = valid[0] && (tag0 == tag);
    assign hit1     = valid[1] && (tag1 == tag);
    assign hit      = lookup && (hit0 || hit1);
    assign hit_data = hit1 ? data1 : data0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 2'b00;
            ptr   <= 1'b0;
            tag0  <= '0;
            tag1  <= '0;
            data0 <= '0;
            data1 <= '0;
        end else if (flush) begin
            valid <= 2'b00;
        end else if (we) begin
            if (ptr) begin
                tag1  <= wtag;
                data1 <= wdata;
            end else begin
                tag0  <= wtag;
                data0 <= wdata;
            end
            valid[ptr] <= 1'b1;
            ptr        <= ~ptr;
        end
    end

endmodule

// File: rtl/jtframe_rom_req.sv
// jtframe_rom_req: game-side SDRAM ROM requester with a 2-entry word cache.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   downloading                flushes the cache and abandons requests
//   addr, addr_ok              game ROM address and request level
//   dout, data_ok              data for the address of the previous cycle
//   sdram_req/ack/addr/bank    request handshake towards the SDRAM arbiter
//   data_read, data_rdy        returned 32-bit word and its strobe
// Optional macro JTFRAME_ROM_REQ_TIMEOUT_EN: re-issues the request when
// data_rdy does not arrive within 256 cycles of the ack.
module jtframe_rom_req
    import jtframe_rom_req_pkg::*;
#(
    parameter int          AW     = 18,
    parameter int          DW     = 8,
    parameter logic [21:0] OFFSET = 22'h0,
    parameter logic [1:0]  BANK   = 2'd0
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          downloading,
    input  logic [AW-1:0] addr,
    input  logic          addr_ok,
    output logic [DW-1:0] dout,
    output logic          data_ok,
    output logic          sdram_req,
    input  logic          sdram_ack,
    output logic [21:0]   sdram_addr,
    output logic [1:0]    sdram_bank,
    input  logic [31:0]   data_read,
    input  logic          data_rdy
);

    localparam int LSB = lsb_w(DW);
    localparam int TW  = AW - LSB;

    state_t        state;
    logic [AW-1:0] addr_q;
    logic          ok_q;
    logic [TW-1:0] tag_q, miss_tag;
    logic [1:0]    sel;
    logic          hit, fill;
    logic [31:0]   hit_data;
    logic [DW-1:0] slice, dout_q;
`ifdef JTFRAME_ROM_REQ_TIMEOUT_EN
    logic [7:0]    timer;
`endif

    assign tag_q = addr_q[AW-1:LSB];

    if (LSB == 2) begin : g_sel4
        assign sel = addr_q[1:0];
    end else if (LSB == 1) begin : g_sel2
        assign sel = {1'b0, addr_q[0]};
    end else begin : g_sel1
        assign sel = 2'b00;
    end

    assign slice      = hit_data[int'(sel) * DW +: DW];
    assign data_ok    = (state == IDLE) && hit && !downloading;
    assign dout       = data_ok ? slice : dout_q;
    assign sdram_bank = BANK;

    // ack and data_rdy together in REQ complete the fill at once
    assign fill = !downloading && data_rdy &&
                  ((state == REQ && sdram_ack) || state == WAIT);

    jtframe_rom_req_cache #(.TW(TW)) u_cache (
        .clk      (clk),
        .rst      (rst),
        .flush    (downloading),
        .lookup   (ok_q),
        .tag      (tag_q),
        .hit      (hit),
        .hit_data (hit_data),
        .we       (fill),
        .wtag     (miss_tag),
        .wdata    (data_read)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            ok_q   <= 1'b0;
        end else begin
            addr_q <= addr;
            ok_q   <= addr_ok;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sdram_req  <= 1'b0;
            sdram_addr <= OFFSET;
            miss_tag   <= '0;
            dout_q     <= '0;
`ifdef JTFRAME_ROM_REQ_TIMEOUT_EN
            timer      <= '0;
`endif
        end else if (downloading) begin
            state     <= IDLE;
            sdram_req <= 1'b0;
        end else begin
            if (data_ok) dout_q <= slice;
            unique case (state)
                IDLE: begin
                    if (ok_q && !hit) begin
                        state      <= REQ;
                        sdram_req  <= 1'b1;
                        sdram_addr <= OFFSET + 22'({tag_q, 1'b0});
                        miss_tag   <= tag_q;
                    end
                end
                REQ: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        state     <= data_rdy ? IDLE : WAIT;
`ifdef JTFRAME_ROM_REQ_TIMEOUT_EN
                        timer     <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (data_rdy) begin
                        state <= IDLE;
`ifdef JTFRAME_ROM_REQ_TIMEOUT_EN
                    end else if (timer == TIMEOUT) begin
                        // sdram_addr still holds the lost request
                        state     <= REQ;
                        sdram_req <= 1'b1;
                    end else begin
                        timer <= timer + 8'd1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_rom_req.sv
// tb_jtframe_rom_req: directed sequences, a vector table and a
// randomized run against a 2-entry FIFO cache model.
module tb_jtframe_rom_req;

    localparam int          AW     = 18;
    localparam int          DW     = 8;
    localparam logic [21:0] OFFSET = 22'h1000;
    localparam logic [1:0]  BANK   = 2'd2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          downloading = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          addr_ok = 1'b0;
    logic [DW-1:0] dout;
    logic          data_ok;
    logic          sdram_req;
    logic          sdram_ack = 1'b0;
    logic [21:0]   sdram_addr;
    logic [1:0]    sdram_bank;
    logic [31:0]   data_read = '0;
    logic          data_rdy = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;
    int mq[$];

    always #5 clk = ~clk;

    jtframe_rom_req #(
        .AW(AW), .DW(DW), .OFFSET(OFFSET), .BANK(BANK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .downloading (downloading),
        .addr        (addr),
        .addr_ok     (addr_ok),
        .dout        (dout),
        .data_ok     (data_ok),
        .sdram_req   (sdram_req),
        .sdram_ack   (sdram_ack),
        .sdram_addr  (sdram_addr),
        .sdram_bank  (sdram_bank),
        .data_read   (data_read),
        .data_rdy    (data_rdy)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic          ok;
        logic          exp_ok;
        logic [7:0]    exp_d;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!sdram_req && n < 8) begin
            tick();
            n++;
        end
        chk(name, 32'(sdram_req), 32'd1);
    endtask

    function automatic logic [21:0] word_addr(input logic [AW-1:0] a);
        return OFFSET + 22'(a >> 2) * 22'd2;
    endfunction

    function automatic logic [31:0] mem_word(input logic [21:0] sa);
        return (32'(sa) * 32'h9E3779B1) ^ 32'h5A5AA5A5;
    endfunction

    function automatic logic [7:0] exp_byte(input logic [AW-1:0] a);
        logic [31:0] w;
        w = mem_word(word_addr(a));
        return w[8*a[1:0] +: 8];
    endfunction

    function automatic bit mq_has(input int t);
        foreach (mq[i]) if (mq[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    // Miss on a, serve it with word d, then check the hit that follows
    task automatic fill(input logic [AW-1:0] a, input logic [31:0] d,
                        input bit same);
        addr    = a;
        addr_ok = 1'b1;
        tick();
        chk("miss_no_ok", 32'(data_ok), 32'd0);
        wait_req("miss_req");
        chk("miss_addr", 32'(sdram_addr), 32'(word_addr(a)));
        chk("miss_bank", 32'(sdram_bank), 32'(BANK));
        if (same) begin
            sdram_ack = 1'b1;
            data_rdy  = 1'b1;
            data_read = d;
            tick();
            sdram_ack = 1'b0;
            data_rdy  = 1'b0;
            chk("same_req_low", 32'(sdram_req), 32'd0);
            chk("same_ok", 32'(data_ok), 32'd1);
        end else begin
            sdram_ack = 1'b1;
            tick();
            sdram_ack = 1'b0;
            chk("ack_req_low", 32'(sdram_req), 32'd0);
            chk("wait_no_ok", 32'(data_ok), 32'd0);
            tick();
            data_rdy  = 1'b1;
            data_read = d;
            tick();
            data_rdy  = 1'b0;
            chk("fill_ok", 32'(data_ok), 32'd1);
        end
        chk("fill_dout", 32'(dout), 32'(d[8*a[1:0] +: 8]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt[0] = '{18'h5,  1'b1, 1'b1, 8'hBB};
        vt[1] = '{18'h4,  1'b1, 1'b1, 8'hAA};
        vt[2] = '{18'h6,  1'b1, 1'b1, 8'hCC};
        vt[3] = '{18'h0,  1'b0, 1'b0, 8'hCC};
        vt[4] = '{18'h7,  1'b1, 1'b1, 8'hDD};
        vt[5] = '{18'h9,  1'b1, 1'b1, 8'h22};
        vt[6] = '{18'h8,  1'b1, 1'b1, 8'h11};
        vt[7] = '{18'hB,  1'b1, 1'b1, 8'h44};
        vt[8] = '{18'hA,  1'b0, 1'b0, 8'h44};
        vt[9] = '{18'h4,  1'b1, 1'b1, 8'hAA};

        // reset state
        tick();
        chk("rst_req", 32'(sdram_req), 32'd0);
        chk("rst_addr", 32'(sdram_addr), 32'(OFFSET));
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_ok", 32'(data_ok), 32'd0);
        chk("rst_bank", 32'(sdram_bank), 32'(BANK));
        rst = 1'b0;
        tick();

        // first miss: ack three cycles after the request, data three later
        addr    = 18'h5;
        addr_ok = 1'b1;
        tick();
        chk("t1_ok0", 32'(data_ok), 32'd0);
        chk("t1_req0", 32'(sdram_req), 32'd0);
        tick();
        chk("t1_req1", 32'(sdram_req), 32'd1);
        chk("t1_addr", 32'(sdram_addr), 32'h1002);
        tick();
        chk("t1_req_held", 32'(sdram_req), 32'd1);
        tick();
        chk("t1_req_held2", 32'(sdram_req), 32'd1);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        chk("t1_req_drop", 32'(sdram_req), 32'd0);
        tick();
        chk("t1_wait_ok", 32'(data_ok), 32'd0);
        tick();
        data_rdy  = 1'b1;
        data_read = 32'hDDCCBBAA;
        tick();
        data_rdy  = 1'b0;
        data_read = '0;
        chk("t1_ok", 32'(data_ok), 32'd1);
        chk("t1_dout", 32'(dout), 32'hBB);

        fill(18'h8, 32'h44332211, 1'b0);

        // back-to-back hits from the vector table
        for (int i = 0; i < 10; i++) begin
            addr    = vt[i].a;
            addr_ok = vt[i].ok;
            tick();
            chk($sformatf("vec%0d_ok", i), 32'(data_ok), 32'(vt[i].exp_ok));
            chk($sformatf("vec%0d_dout", i), 32'(dout), 32'(vt[i].exp_d));
            chk($sformatf("vec%0d_req", i), 32'(sdram_req), 32'd0);
        end

        // third tag evicts the oldest entry (tag 1)
        fill(18'hC, 32'h0C0B0A09, 1'b0);
        addr = 18'h9;
        tick();
        chk("evict_keep_ok", 32'(data_ok), 32'd1);
        chk("evict_keep_dout", 32'(dout), 32'h22);
        // tag 1 refetched with ack and data_rdy together
        fill(18'h5, 32'hDDCCBBAA, 1'b1);
        tick();
        chk("same_hold_ok", 32'(data_ok), 32'd1);
        chk("same_hold_req", 32'(sdram_req), 32'd0);
        addr = 18'hC;
        tick();
        chk("same_t3_ok", 32'(data_ok), 32'd1);
        chk("same_t3_dout", 32'(dout), 32'h09);
        fill(18'h8, 32'h44332211, 1'b0);

        // download during WAIT abandons the request
        addr    = 18'h20;
        addr_ok = 1'b1;
        tick();
        wait_req("dl_req");
        sdram_ack = 1'b1;
        tick();
        sdram_ack   = 1'b0;
        downloading = 1'b1;
        addr_ok     = 1'b0;
        tick();
        chk("dl_req_low", 32'(sdram_req), 32'd0);
        chk("dl_ok", 32'(data_ok), 32'd0);
        downloading = 1'b0;
        data_rdy    = 1'b1;
        data_read   = 32'hBADBAD00;
        tick();
        data_rdy = 1'b0;
        chk("dl_late_ok", 32'(data_ok), 32'd0);
        chk("dl_late_req", 32'(sdram_req), 32'd0);
        fill(18'h9, 32'h44332211, 1'b0);
        fill(18'h20, 32'h87654321, 1'b0);

`ifdef JTFRAME_ROM_REQ_TIMEOUT_EN
        begin
            int n;
            logic [21:0] sa;
            addr = 18'h44;
            tick();
            wait_req("to_req");
            sa        = sdram_addr;
            sdram_ack = 1'b1;
            tick();
            sdram_ack = 1'b0;
            n = 1;
            while (!sdram_req && n < 400) begin
                tick();
                n++;
            end
            chk("to_cycles", 32'(n >= 256 && n <= 258), 32'd1);
            chk("to_addr", 32'(sdram_addr), 32'(sa));
            sdram_ack = 1'b1;
            data_rdy  = 1'b1;
            tick();
            sdram_ack = 1'b0;
            data_rdy  = 1'b0;
        end
`endif

        // reset mid-request drops sdram_req without a clock edge
        addr    = 18'h40;
        addr_ok = 1'b1;
        tick();
        wait_req("rr_req");
        #2;
        rst = 1'b1;
        #1;
        chk("rr_req", 32'(sdram_req), 32'd0);
        chk("rr_addr", 32'(sdram_addr), 32'(OFFSET));
        chk("rr_dout", 32'(dout), 32'd0);
        addr_ok = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rr_after", 32'(sdram_req), 32'd0);

        // randomized traffic with a responding SDRAM
        begin
            logic [AW-1:0] cur_a;
            logic [21:0]   req_sa;
            bit            cur_ok, got;
            int            seg_left, seg_len, rs, cnt, t;
            cur_a    = '0;
            req_sa   = '0;
            cur_ok   = 1'b0;
            got      = 1'b0;
            seg_left = 0;
            seg_len  = 0;
            rs       = 0;
            cnt      = 0;
            mq.delete();
            for (int c = 0; c < 3000; c++) begin
                tick();
                if (data_ok) begin
                    chk("rnd_ok_valid", 32'(cur_ok), 32'd1);
                    chk("rnd_dout", 32'(dout), 32'(exp_byte(cur_a)));
                    chk("rnd_hit_cached", 32'(mq_has(int'(cur_a >> 2))), 32'd1);
                    got = 1'b1;
                end
                if (rs == 0 && sdram_req) begin
                    req_sa = sdram_addr;
                    t = int'((req_sa - OFFSET) >> 1);
                    chk("rnd_req_even", 32'(req_sa[0]), 32'd0);
                    chk("rnd_req_uncached", 32'(mq_has(t)), 32'd0);
                    chk("rnd_req_bank", 32'(sdram_bank), 32'(BANK));
                    rs  = 1;
                    cnt = $urandom_range(0, 3);
                end else if (rs == 1) begin
                    chk("rnd_req_held", 32'(sdram_req), 32'd1);
                    chk("rnd_req_stable", 32'(sdram_addr), 32'(req_sa));
                end
                sdram_ack = 1'b0;
                data_rdy  = 1'b0;
                data_read = $urandom;
                if (rs == 1) begin
                    if (cnt == 0) begin
                        sdram_ack = 1'b1;
                        cnt = $urandom_range(0, 3);
                        if (cnt == 0) begin
                            data_rdy  = 1'b1;
                            data_read = mem_word(req_sa);
                            mq.push_back(int'((req_sa - OFFSET) >> 1));
                            if (mq.size() > 2) void'(mq.pop_front());
                            rs = 0;
                        end else begin
                            rs = 2;
                        end
                    end else begin
                        cnt--;
                    end
                end else if (rs == 2) begin
                    cnt--;
                    if (cnt == 0) begin
                        data_rdy  = 1'b1;
                        data_read = mem_word(req_sa);
                        mq.push_back(int'((req_sa - OFFSET) >> 1));
                        if (mq.size() > 2) void'(mq.pop_front());
                        rs = 0;
                    end
                end
                if (seg_left == 0) begin
                    if (cur_ok && seg_len >= 28)
                        chk("rnd_live", 32'(got), 32'd1);
                    seg_len  = $urandom_range(1, 30);
                    seg_left = seg_len;
                    cur_a    = AW'($urandom_range(0, 23));
                    cur_ok   = ($urandom_range(0, 4) != 0);
                    got      = 1'b0;
                end
                seg_left--;
                addr    = cur_a;
                addr_ok = cur_ok;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
